// File: rtl/lcd_frame_capture.sv
// Ping-pong frame capture: copies one framebuffer frame into the back bank of a
// two-bank display RAM, then swaps banks during vertical blank.
module lcd_frame_capture #(
  parameter int FB_BYTES = 768,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_complete,
  input  logic              vblank,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic              dst_we,
  output logic [ADDR_W:0]   dst_addr,
  output logic [DATA_W-1:0] dst_data,
  output logic              disp_bank,
  output logic              busy,
  output logic [7:0]        frames_swapped,
  output logic [7:0]        overrun_count
);

  typedef enum logic [1:0] {IDLE, COPY, DRAIN, PENDING} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_valid;
  logic              swap_now;

  assign swap_now = (state == PENDING) && vblank;

  // Source data arrives one clock after the read strobe, so the write side is
  // a one-stage delayed copy of the read address and strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      wr_valid       <= 1'b0;
      src_rd         <= 1'b0;
      src_addr       <= '0;
      disp_bank      <= 1'b0;
      busy           <= 1'b0;
      frames_swapped <= 8'd0;
      overrun_count  <= 8'd0;
    end else begin
      wr_valid <= src_rd;
      wr_ptr   <= src_addr;
      src_rd   <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_complete) begin
            rd_ptr <= '0;
            state  <= COPY;
            busy   <= 1'b1;
          end
        end
        COPY: begin
          src_rd   <= 1'b1;
          src_addr <= rd_ptr;
          rd_ptr   <= rd_ptr + 1'b1;
          if (rd_ptr == LAST_ADDR) state <= DRAIN;
        end
        DRAIN: begin
          state <= PENDING;
        end
        PENDING: begin
          if (vblank) begin
            disp_bank      <= ~disp_bank;
            frames_swapped <= frames_swapped + 8'd1;
            if (frame_complete) begin
              rd_ptr <= '0;
              state  <= COPY;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A pulse that cannot start or chain a copy is dropped and counted.
      if (frame_complete && (state != IDLE) && !swap_now && (overrun_count != 8'hFF))
        overrun_count <= overrun_count + 8'd1;
    end
  end

  assign dst_we   = wr_valid;
  assign dst_addr = {~disp_bank, wr_ptr};
  assign dst_data = src_data;

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Self-checking bench for lcd_frame_capture: scoreboarded display-RAM writes
// plus a table of PENDING-state vectors and hand-written latency/abort sequences.
module tb_lcd_frame_capture;

  localparam int FB = 768;

  logic        clk;
  logic        reset_n;
  logic        frame_complete;
  logic        vblank;
  logic        src_rd;
  logic [9:0]  src_addr;
  logic [7:0]  src_data;
  logic        dst_we;
  logic [10:0] dst_addr;
  logic [7:0]  dst_data;
  logic        disp_bank;
  logic        busy;
  logic [7:0]  frames_swapped;
  logic [7:0]  overrun_count;

  lcd_frame_capture #(.FB_BYTES(FB), .ADDR_W(10), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .frame_complete(frame_complete), .vblank(vblank),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_data(dst_data),
    .disp_bank(disp_bank), .busy(busy),
    .frames_swapped(frames_swapped), .overrun_count(overrun_count)
  );

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic       vb;
    logic       fc;
    logic       exp_bank;
    logic       exp_busy;
    logic [7:0] exp_frames;
    logic [7:0] exp_overrun;
  } vec_t;

  wr_t        exp_q[$];
  logic [7:0] mem [0:1023];
  int         checks = 0;
  int         errors = 0;
  int         write_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer read port model: data valid one clock after the address.
  always @(posedge clk) src_data <= mem[src_addr];

  function automatic logic [7:0] pat(input int i, input int seed);
    return 8'(i) ^ 8'hA5 ^ 8'(seed * 37);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic vb, input logic fc);
    vblank         = vb;
    frame_complete = fc;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic fillMem(input int seed);
    for (int i = 0; i < 1024; i++) mem[i] = pat(i, seed);
  endtask

  task automatic pushFrame(input logic bank, input int seed);
    for (int i = 0; i < FB; i++) exp_q.push_back({bank, 10'(i), pat(i, seed)});
  endtask

  // Loads the source, queues the expected writes and pulses frame_complete (edge E0).
  task automatic startFrame(input logic bank, input int seed);
    fillMem(seed);
    pushFrame(bank, seed);
    frame_complete = 1'b1;
    step();
    frame_complete = 1'b0;
  endtask

  always @(negedge clk) begin
    if (dst_we) begin
      write_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected no write", dst_addr, dst_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(dst_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(dst_data), 32'(e.data));
      end
    end
  end

  initial begin
    vec_t pend_tbl[5];
    int   wc0;

    pend_tbl[0] = '{vb: 1'b0, fc: 1'b1, exp_bank: 1'b0, exp_busy: 1'b1, exp_frames: 8'd0, exp_overrun: 8'd1};
    pend_tbl[1] = '{vb: 1'b0, fc: 1'b0, exp_bank: 1'b0, exp_busy: 1'b1, exp_frames: 8'd0, exp_overrun: 8'd1};
    pend_tbl[2] = '{vb: 1'b1, fc: 1'b0, exp_bank: 1'b1, exp_busy: 1'b0, exp_frames: 8'd1, exp_overrun: 8'd1};
    pend_tbl[3] = '{vb: 1'b1, fc: 1'b0, exp_bank: 1'b1, exp_busy: 1'b0, exp_frames: 8'd1, exp_overrun: 8'd1};
    pend_tbl[4] = '{vb: 1'b0, fc: 1'b0, exp_bank: 1'b1, exp_busy: 1'b0, exp_frames: 8'd1, exp_overrun: 8'd1};

    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    fillMem(0);

    // Reset held while frame_complete toggles.
    for (int i = 0; i < 6; i++) begin
      frame_complete = ~frame_complete;
      step();
    end
    frame_complete = 1'b0;
    checkOutput("rst_disp_bank", 32'(disp_bank), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dst_we", 32'(dst_we), 32'd0);
    checkOutput("rst_src_rd", 32'(src_rd), 32'd0);
    checkOutput("rst_src_addr", 32'(src_addr), 32'd0);
    checkOutput("rst_frames", 32'(frames_swapped), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_count), 32'd0);
    reset_n = 1'b1;
    step(2);

    // Basic copy with exact latency points.
    wc0 = write_count;
    startFrame(1'b1, 0);
    for (int k = 1; k <= FB + 2; k++) begin
      step();
      if (k == 1) begin
        checkOutput("first_src_rd", 32'(src_rd), 32'd1);
        checkOutput("first_src_addr", 32'(src_addr), 32'd0);
        checkOutput("first_no_we", 32'(dst_we), 32'd0);
      end
      if (k == 2) checkOutput("first_dst_we", 32'(dst_we), 32'd1);
      if (k == FB) begin
        checkOutput("last_src_rd", 32'(src_rd), 32'd1);
        checkOutput("last_src_addr", 32'(src_addr), 32'(FB - 1));
      end
      if (k == FB + 1) begin
        checkOutput("drain_src_rd", 32'(src_rd), 32'd0);
        checkOutput("last_dst_we", 32'(dst_we), 32'd1);
      end
      if (k == FB + 2) checkOutput("after_last_we", 32'(dst_we), 32'd0);
    end
    step(5);
    checkOutput("basic_writes", 32'(write_count - wc0), 32'(FB));
    checkOutput("basic_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("pend_busy", 32'(busy), 32'd1);
    checkOutput("pend_bank", 32'(disp_bank), 32'd0);

    // PENDING vectors: an overrun, then the vblank swap, then idle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(pend_tbl[i].vb, pend_tbl[i].fc);
      step();
      checkOutput($sformatf("tbl%0d_bank", i), 32'(disp_bank), 32'(pend_tbl[i].exp_bank));
      checkOutput($sformatf("tbl%0d_busy", i), 32'(busy), 32'(pend_tbl[i].exp_busy));
      checkOutput($sformatf("tbl%0d_frames", i), 32'(frames_swapped), 32'(pend_tbl[i].exp_frames));
      checkOutput($sformatf("tbl%0d_overrun", i), 32'(overrun_count), 32'(pend_tbl[i].exp_overrun));
    end
    applyStimulus(1'b0, 1'b0);
    step(2);

    // Early vblank: swap lands on the first PENDING edge, E0+770.
    vblank = 1'b1;
    wc0 = write_count;
    startFrame(1'b0, 1);
    step(FB + 1);
    checkOutput("early_bank_hold", 32'(disp_bank), 32'd1);
    checkOutput("early_busy_hold", 32'(busy), 32'd1);
    step();
    checkOutput("early_bank_swap", 32'(disp_bank), 32'd0);
    checkOutput("early_frames", 32'(frames_swapped), 32'd2);
    checkOutput("early_busy", 32'(busy), 32'd0);
    checkOutput("early_writes", 32'(write_count - wc0), 32'(FB));
    vblank = 1'b0;
    step(2);

    // Overrun pulses during COPY and DRAIN.
    wc0 = write_count;
    startFrame(1'b1, 2);
    for (int k = 1; k <= FB + 2; k++) begin
      frame_complete = (k == 100) || (k == FB + 1);
      step();
    end
    frame_complete = 1'b0;
    step(3);
    checkOutput("ovr_count", 32'(overrun_count), 32'd3);
    checkOutput("ovr_writes", 32'(write_count - wc0), 32'(FB));
    checkOutput("ovr_bank_hold", 32'(disp_bank), 32'd0);
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    step(3);
    checkOutput("ovr_bank", 32'(disp_bank), 32'd1);
    checkOutput("ovr_frames", 32'(frames_swapped), 32'd3);
    checkOutput("ovr_busy", 32'(busy), 32'd0);

    // Simultaneous vblank and frame_complete in PENDING chains a new copy.
    wc0 = write_count;
    startFrame(1'b0, 3);
    step(FB + 2);
    checkOutput("sim_pend_busy", 32'(busy), 32'd1);
    fillMem(4);
    pushFrame(1'b1, 4);
    applyStimulus(1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0);
    checkOutput("sim_bank", 32'(disp_bank), 32'd0);
    checkOutput("sim_frames", 32'(frames_swapped), 32'd4);
    checkOutput("sim_overrun", 32'(overrun_count), 32'd3);
    checkOutput("sim_busy", 32'(busy), 32'd1);
    step();
    checkOutput("sim_src_rd", 32'(src_rd), 32'd1);
    checkOutput("sim_src_addr", 32'(src_addr), 32'd0);
    step(FB + 1);
    checkOutput("sim_writes", 32'(write_count - wc0), 32'(2 * FB));
    checkOutput("sim_queue_empty", 32'(exp_q.size()), 32'd0);
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    checkOutput("sim_bank2", 32'(disp_bank), 32'd1);
    checkOutput("sim_frames2", 32'(frames_swapped), 32'd5);
    step(2);

    // Abort at write 300 via asynchronous reset.
    startFrame(1'b0, 5);
    step(301);
    checkOutput("abort_we", 32'(dst_we), 32'd1);
    checkOutput("abort_addr", 32'(dst_addr), 32'h0000012B);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_bank", 32'(disp_bank), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_we_off", 32'(dst_we), 32'd0);
    checkOutput("abort_src_rd", 32'(src_rd), 32'd0);
    checkOutput("abort_frames", 32'(frames_swapped), 32'd0);
    checkOutput("abort_overrun", 32'(overrun_count), 32'd0);
    exp_q.delete();
    step(2);
    reset_n = 1'b1;
    step(2);
    wc0 = write_count;
    startFrame(1'b1, 6);
    step(FB + 2);
    checkOutput("post_abort_writes", 32'(write_count - wc0), 32'(FB));
    checkOutput("post_abort_queue", 32'(exp_q.size()), 32'd0);
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    checkOutput("post_abort_bank", 32'(disp_bank), 32'd1);
    checkOutput("post_abort_frames", 32'(frames_swapped), 32'd1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
